sseg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.

---
 rtl/sseg_pkg.sv | 27 ++
 rtl/sseg_hex_decode.sv | 17 +
 rtl/sseg_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t : scan FSM states (blanking gap, digit lit)
//   - SEG_OFF      : cathode pattern with every segment and the dp dark
//   - AN_OFF       : anode pattern with every digit dark
//   - HEX_SEG_LUT  : hex digit -> active-low segments, bit order g..a
// -----------------------------------------------------------------------------
package sseg_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] HEX_SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/sseg_hex_decode.sv
// -----------------------------------------------------------------------------
// sseg_hex_decode
// Combinational hex nibble to seven-segment decoder (active-low segments).
// Ports:
//   hex_i  in  4  hex digit value
//   seg_o  out 7  segments g..a, 0 = lit
// -----------------------------------------------------------------------------
import sseg_pkg::*;

module sseg_hex_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_LUT[hex_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. A packed hex word is taken over a valid/ready handshake into a
// shadow register once per frame, just before digit 0 is lit, so a frame never
// mixes old and new digits. Each digit slot is a blanking gap (all anodes off)
// followed by the lit phase.
//
// Parameters:
//   NUM_DIG    digits scanned (1..8), digit 0 = rightmost = SSEG_AN[0]
//   ON_CYC     clocks each digit is lit (>=1)
//   BLANK_CYC  clocks of blanking before each digit (>=0, 0 = no gap)
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-low
//   upd_data   in   32  packed hex digits, nibble i -> digit i
//   upd_dp     in   8   decimal point per digit, 1 = lit
//   upd_valid  in   1   producer offers upd_data/upd_dp
//   upd_ready  out  1   shadow accepts an update this cycle
//   dig_en     in   8   live per-digit enable, 0 = digit dark in its slot
//   frame_tick out  1   pulse on the last lit cycle of the last digit
//   SSEG_AN    out  8   anodes, active-low
//   SSEG_CA    out  8   cathodes, active-low, [6:0] = g..a, [7] = dp
//
// Build option:
//   SSEG_LZB_EN  leading-zero blanking: digit i>0 is dark (anode still
//                driven) when nibble i and every higher in-range nibble are
//                zero and its dp is off. Undefined: all enabled digits show.
// -----------------------------------------------------------------------------
import sseg_pkg::*;

module sseg_scan_ctrl #(
    parameter int NUM_DIG   = 8,
    parameter int ON_CYC    = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_dp,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [7:0]  dig_en,
    output logic        frame_tick,
    output logic [7:0]  SSEG_AN,
    output logic [7:0]  SSEG_CA
);

    localparam int MAX_CYC      = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW           = $clog2(MAX_CYC + 1);
    localparam int BLANK_LAST_I = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LAST_I);
    localparam logic [2:0]    DIG_LAST   = 3'(NUM_DIG - 1);

    // With no blanking gap every slot starts directly in the lit phase.
    localparam scan_state_t ENTRY_STATE = (BLANK_CYC > 0) ? S_BLANK : S_ON;

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [31:0]   shadow_data_q, shadow_data_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic          cap_done_q, cap_done_d;
    logic          ready_q, ready_d;
    logic          tick_q, tick_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    ca_q, ca_d;

    logic          last_on;
    logic          frame_end;
    logic          handshake;
    logic          pre_phase_d;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;
    logic          lit;
    logic          lzb_dark;

    // ---------------------------------------------------------------------
    // Scan sequencing
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        dig_d     = dig_q;
        last_on   = (state_q == S_ON) && (cnt_q == ON_LAST);
        frame_end = last_on && (dig_q == DIG_LAST);

        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (last_on) begin
                    state_d = ENTRY_STATE;
                    cnt_d   = '0;
                    dig_d   = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
                end
            end
            default: begin
                state_d = ENTRY_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Update handshake and shadow
    // ---------------------------------------------------------------------
    // upd_ready tracks the FSM state (not the display latency): it is high
    // while the scan sits in the phase just before digit 0 lights. cap_done
    // limits captures to one per frame and is cleared as the frame ends, so
    // the very next window opens again.
    always_comb begin
        handshake     = upd_valid && ready_q;
        shadow_data_d = handshake ? upd_data : shadow_data_q;
        shadow_dp_d   = handshake ? upd_dp   : shadow_dp_q;
        cap_done_d    = frame_end ? 1'b0 : (cap_done_q | handshake);

        if (BLANK_CYC > 0)
            pre_phase_d = (dig_d == 3'd0) && (state_d == S_BLANK);
        else
            pre_phase_d = (dig_d == 3'd0) && (state_d == S_ON) && (cnt_d == '0);

        ready_d = pre_phase_d && !cap_done_d;
        tick_d  = (state_d == S_ON) && (cnt_d == ON_LAST) && (dig_d == DIG_LAST);
    end

    // ---------------------------------------------------------------------
    // Segment / anode generation
    // ---------------------------------------------------------------------
    // The next-shadow value is used so a capture on the edge that also
    // registers digit 0's first lit cycle (no blanking gap) shows the new
    // word immediately instead of one stale digit.
    assign cur_nib = shadow_data_d[{dig_q, 2'b00} +: 4];

    sseg_hex_decode u_dec (
        .hex_i (cur_nib),
        .seg_o (cur_seg)
    );

`ifdef SSEG_LZB_EN
    logic [7:0] lead_zero;
    logic       hz;

    // lead_zero[d] = nibble d and all higher in-range nibbles are zero.
    always_comb begin
        lead_zero = '0;
        hz        = 1'b1;
        for (int d = 7; d >= 0; d--) begin
            if (d < NUM_DIG) begin
                hz           = hz && (shadow_data_d[4*d +: 4] == 4'h0);
                lead_zero[d] = hz;
            end
        end
    end

    assign lzb_dark = (dig_q != 3'd0) && lead_zero[dig_q] && !shadow_dp_d[dig_q];
`else
    assign lzb_dark = 1'b0;
`endif

    always_comb begin
        lit  = (state_q == S_ON) && dig_en[dig_q];
        an_d = lit ? ~(8'b1 << dig_q) : AN_OFF;
        ca_d = (lit && !lzb_dark) ? {~shadow_dp_d[dig_q], cur_seg} : SEG_OFF;
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ENTRY_STATE;
            cnt_q         <= '0;
            dig_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            cap_done_q    <= 1'b0;
            ready_q       <= 1'b0;
            tick_q        <= 1'b0;
            an_q          <= AN_OFF;
            ca_q          <= SEG_OFF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            cap_done_q    <= cap_done_d;
            ready_q       <= ready_d;
            tick_q        <= tick_d;
            an_q          <= an_d;
            ca_q          <= ca_d;
        end
    end

    assign upd_ready  = ready_q;
    assign frame_tick = tick_q;
    assign SSEG_AN    = an_q;
    assign SSEG_CA    = ca_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
// Directed bench for sseg_scan_ctrl with NUM_DIG=2, ON_CYC=4, BLANK_CYC=2.
// A frame is 12 clocks. Frame positions p=0..11 are counted from the first
// sample after the scan (re)enters digit 0's blanking gap:
//   p0-1 blank, p2-5 digit 0 lit, p6-7 blank, p8-11 digit 1 lit.
// frame_tick is seen at p10, upd_ready at p11 (gap of the next frame) and p0.
// Honours SSEG_LZB_EN for the leading-zero case.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] upd_data;
    logic [7:0]  upd_dp;
    logic        upd_valid;
    logic        upd_ready;
    logic [7:0]  dig_en;
    logic        frame_tick;
    logic [7:0]  SSEG_AN;
    logic [7:0]  SSEG_CA;

    int total = 0;
    int bad   = 0;

`ifdef SSEG_LZB_EN
    localparam logic [7:0] LEAD0_CA1 = 8'hFF;
`else
    localparam logic [7:0] LEAD0_CA1 = 8'hC0;
`endif

    sseg_scan_ctrl #(
        .NUM_DIG   (2),
        .ON_CYC    (4),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .dig_en     (dig_en),
        .frame_tick (frame_tick),
        .SSEG_AN    (SSEG_AN),
        .SSEG_CA    (SSEG_CA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks frame positions p_lo..p_hi, one sample per falling edge.
    task automatic frame(input string nm, input int p_lo, input int p_hi,
                         input logic [7:0] an0, input logic [7:0] ca0,
                         input logic [7:0] an1, input logic [7:0] ca1,
                         input logic r0, input logic r11);
        logic [7:0] ea;
        logic [7:0] ec;
        logic       er;
        logic       et;
        for (int p = p_lo; p <= p_hi; p++) begin
            @(negedge clk);
            if (p < 2 || (p >= 6 && p < 8)) begin
                ea = 8'hFF;
                ec = 8'hFF;
            end else if (p < 6) begin
                ea = an0;
                ec = ca0;
            end else begin
                ea = an1;
                ec = ca1;
            end
            er = (p == 0) ? r0 : ((p == 11) ? r11 : 1'b0);
            et = (p == 10);
            chk($sformatf("%s.an[%0d]", nm, p), SSEG_AN, ea);
            chk($sformatf("%s.ca[%0d]", nm, p), SSEG_CA, ec);
            chk($sformatf("%s.ready[%0d]", nm, p), {7'b0, upd_ready}, {7'b0, er});
            chk($sformatf("%s.tick[%0d]", nm, p), {7'b0, frame_tick}, {7'b0, et});
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".an"},    SSEG_AN, 8'hFF);
        chk({nm, ".ca"},    SSEG_CA, 8'hFF);
        chk({nm, ".ready"}, {7'b0, upd_ready}, 8'h00);
        chk({nm, ".tick"},  {7'b0, frame_tick}, 8'h00);
    endtask

    initial begin
        rst       = 1'b0;
        upd_data  = 32'h0;
        upd_dp    = 8'h0;
        upd_valid = 1'b0;
        dig_en    = 8'hFF;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b1;

        // Idle after reset: shadow is zero, both digits show "0".
        frame("idle", 0, 11, 8'hFE, 8'hC0, 8'hFD, 8'hC0, 1'b1, 1'b1);

        // Offer 0x21 with valid held; captured in the gap, shown the same frame.
        upd_data  = 32'h0000_0021;
        upd_valid = 1'b1;
        frame("upd1", 0, 11, 8'hFE, 8'hF9, 8'hFD, 8'hA4, 1'b0, 1'b1);
        frame("upd2", 0, 11, 8'hFE, 8'hF9, 8'hFD, 8'hA4, 1'b0, 1'b1);
        upd_valid = 1'b0;

        // New word offered while digit 1 is lit: not taken until the next gap.
        frame("mid_a", 0, 7, 8'hFE, 8'hF9, 8'hFD, 8'hA4, 1'b1, 1'b1);
        upd_data  = 32'h0000_0043;
        upd_valid = 1'b1;
        frame("mid_b", 8, 11, 8'hFE, 8'hF9, 8'hFD, 8'hA4, 1'b1, 1'b1);
        frame("new43", 0, 11, 8'hFE, 8'hB0, 8'hFD, 8'h99, 1'b0, 1'b1);
        upd_valid = 1'b0;

        // Digit 1 disabled: its slot stays dark, frame timing unchanged.
        dig_en = 8'b0000_0001;
        frame("en01", 0, 11, 8'hFE, 8'hB0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        dig_en = 8'hFF;
        frame("en11", 0, 11, 8'hFE, 8'hB0, 8'hFD, 8'h99, 1'b1, 1'b1);

        // Reset while digit 1 is lit: outputs dark next cycle, shadow cleared.
        frame("prerst", 0, 8, 8'hFE, 8'hB0, 8'hFD, 8'h99, 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst1");
        rst = 1'b1;
        frame("postrst", 0, 11, 8'hFE, 8'hC0, 8'hFD, 8'hC0, 1'b1, 1'b1);

        // Leading zero on digit 1, then with its decimal point lit.
        upd_data  = 32'h0000_0005;
        upd_dp    = 8'h00;
        upd_valid = 1'b1;
        frame("lead0", 0, 11, 8'hFE, 8'h92, 8'hFD, LEAD0_CA1, 1'b0, 1'b1);
        upd_dp = 8'h02;
        frame("lead0dp", 0, 11, 8'hFE, 8'h92, 8'hFD, 8'h40, 1'b0, 1'b1);
        upd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
